// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bus bundle: ICache lookup, flush/redirect inputs, and the
// decode-side handshake. The master modport is the fetch queue itself; the
// slave modport is the environment (ICache + EXU/CSR + IDU).
//   cache_addr/cache_hit/cache_inst/cache_busy : ICache lookup
//   jump_flush/jump_dnpc, cs_flush/cs_dnpc     : redirect sources
//   out_valid/out_ready/out_pc/out_inst        : head-entry handshake
//   q_count                                    : queue occupancy
interface ifu_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic [XLEN-1:0]         cache_addr;
  logic                    cache_hit;
  logic [XLEN-1:0]         cache_inst;
  logic                    cache_busy;
  logic                    jump_flush;
  logic [XLEN-1:0]         jump_dnpc;
  logic                    cs_flush;
  logic [XLEN-1:0]         cs_dnpc;
  logic                    out_ready;
  logic                    out_valid;
  logic [XLEN-1:0]         out_pc;
  logic [XLEN-1:0]         out_inst;
  logic [$clog2(DEPTH):0]  q_count;

  modport master (
    output cache_addr, out_valid, out_pc, out_inst, q_count,
    input  cache_hit, cache_inst, cache_busy, jump_flush, jump_dnpc,
           cs_flush, cs_dnpc, out_ready
  );

  modport slave (
    input  cache_addr, out_valid, out_pc, out_inst, q_count,
    output cache_hit, cache_inst, cache_busy, jump_flush, jump_dnpc,
           cs_flush, cs_dnpc, out_ready
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: drives the fetch PC to a combinational-hit
// ICache and buffers {pc, inst} pairs in a DEPTH-entry FIFO toward decode.
// Optional static prediction (backward-taken branches, JAL) is enabled by
// defining IFU_STATIC_PRED_EN; otherwise the next PC is always PC+4.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   bus          : ifu_fetch_queue_if.master (cache lookup, flushes,
//                  head handshake, occupancy)
module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4,
  parameter int          XLEN     = 32
) (
  input  logic              clock,
  input  logic              reset,
  ifu_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ent_t;

  ent_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d, ppc_q, ppc_d;
  logic             pend_q, pend_d;

  logic             flush, enq, deq;
  logic [XLEN-1:0]  dnpc, incr, pred_pc, inst;

  assign inst  = bus.cache_inst;
  assign flush = bus.cs_flush | bus.jump_flush;
  assign dnpc  = bus.cs_flush ? bus.cs_dnpc : bus.jump_dnpc;

  assign bus.cache_addr = pc_q;
  assign bus.out_valid  = (cnt_q != '0) & ~flush;
  assign bus.out_pc     = mem_q[head_q].pc;
  assign bus.out_inst   = mem_q[head_q].inst;
  assign bus.q_count    = cnt_q;

  assign deq = bus.out_valid & bus.out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign enq = bus.cache_hit & ~flush & ~pend_q &
               ((cnt_q < CW'(DEPTH)) | deq);

`ifdef IFU_STATIC_PRED_EN
  logic [XLEN-1:0] imm_b, imm_j;
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Backward branches predicted taken, forward not taken; JAL always taken.
  always_comb begin
    incr = XLEN'(4);
    if (inst[6:2] == 5'b11000 && inst[31]) incr = imm_b;
    else if (inst[6:2] == 5'b11011)        incr = imm_j;
  end
`else
  assign incr = XLEN'(4);
`endif

  assign pred_pc = pc_q + incr;

  always_comb begin
    pc_d   = pc_q;
    ppc_d  = ppc_q;
    pend_d = pend_q;
    head_d = head_q + AW'(deq);
    tail_d = tail_q + AW'(enq);
    cnt_d  = cnt_q + CW'(enq) - CW'(deq);
    if (enq) pc_d = pred_pc;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      if (bus.cache_busy) begin
        // Keep pc_q so the in-flight refill finishes on its own address;
        // the newest flush target overwrites any older pending one.
        pend_d = 1'b1;
        ppc_d  = dnpc;
      end else begin
        pc_d   = dnpc;
        pend_d = 1'b0;
      end
    end else if (pend_q && !bus.cache_busy) begin
      pc_d   = ppc_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ppc_q  <= '0;
      pend_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ppc_q  <= ppc_d;
      pend_q <= pend_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (enq) mem_q[tail_q] <= '{pc: pc_q, inst: inst};
  end
endmodule
